// File: rtl/cache_mem_pkg.sv
// Shared types and sizing for the cache <-> memory line transfer path.
package cache_mem_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned BEATS       = LINE_W / BEAT_W;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/line_shift_buffer.sv
// Cache-line register with whole-line load, beat-indexed load and
// beat-indexed combinational select.
module line_shift_buffer #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] line_in,
    input  logic              load_beat,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line_out,
    output logic [BEAT_W-1:0] beat_out
);

    logic [LINE_W-1:0] line_q;

    // Line storage: whole-line load takes priority over a single-beat load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load_line) begin
            line_q <= line_in;
        end else if (load_beat) begin
            line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_in;
        end
    end

    // Beat select for the outgoing write data.
    always_comb begin
        beat_out = line_q[beat_idx*BEAT_W +: BEAT_W];
    end

    assign line_out = line_q;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts single cache-line read/write requests into BEATS-long memory
// bursts and answers the cache with a one-cycle response.
module cacheline_burst_adaptor
    import cache_mem_pkg::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_line;
    logic              load_beat;
    logic [BEAT_W-1:0] beat_sel;

    line_shift_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .load_line (load_line),
        .line_in   (line_i),
        .load_beat (load_beat),
        .beat_idx  (cnt_q),
        .beat_in   (burst_i),
        .line_out  (line_o),
        .beat_out  (beat_sel)
    );

    // State, beat counter and latched line address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state, counter control and burst/cache handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        load_line = 1'b0;
        load_beat = 1'b0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;

        case (state_q)
            IDLE: begin
                // Read has priority; a concurrent write is not latched.
                if (read_i) begin
                    addr_d  = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d = RD_BURST;
                end else if (write_i) begin
                    addr_d    = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    load_line = 1'b1;
                    state_d   = WR_BURST;
                end
            end
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = addr_q;
                if (resp_i) begin
                    load_beat = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = addr_q;
                burst_o   = beat_sel;
                if (resp_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor with hand-computed expectations.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int unsigned vectors;
    int unsigned miscompares;

    cacheline_burst_adaptor #(
        .LINE_W (256),
        .BEAT_W (64),
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and outputs are handled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full read with back-to-back beats; data is {b3,b2,b1,b0}.
    task automatic read_line(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_addr, input logic [255:0] data);
        read_i    = 1'b1;
        address_i = addr;
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s read_o c%0d", tag, k + 1), 256'(read_o), 256'(1));
            check($sformatf("%s resp_o c%0d", tag, k + 1), 256'(resp_o), 256'(0));
            check($sformatf("%s addr c%0d", tag, k + 1), 256'(address_o), 256'(exp_addr));
            burst_i = data[k*64 +: 64];
            resp_i  = 1'b1;
            step();
        end
        check({tag, " resp_o done"}, 256'(resp_o), 256'(1));
        check({tag, " read_o done"}, 256'(read_o), 256'(0));
        check({tag, " line_o"}, line_o, data);
        read_i = 1'b0;
        resp_i = 1'b0;
        step();
        check({tag, " resp_o idle"}, 256'(resp_o), 256'(0));
        check({tag, " read_o idle"}, 256'(read_o), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] rd_line, wr_line, x_line, e_line, s_line, r_line, h_line;
        logic [63:0]  exp_beat [7];
        logic         wr_resp [7];

        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        rd_line = {64'h4444444444444444, 64'h3333333333333333,
                   64'h2222222222222222, 64'h1111111111111111};
        wr_line = {64'hD3D3D3D3_00000003, 64'hD2D2D2D2_00000002,
                   64'hD1D1D1D1_00000001, 64'hD0D0D0D0_00000000};
        x_line  = {4{64'hBADBADBADBADBAD0}};
        e_line  = {64'hE3E3E3E3E3E3E3E3, 64'hE2E2E2E2E2E2E2E2,
                   64'hE1E1E1E1E1E1E1E1, 64'hE0E0E0E0E0E0E0E0};
        s_line  = {64'h5A5A000000000004, 64'h5A5A000000000003,
                   64'h5A5A000000000002, 64'h5A5A000000000001};
        r_line  = {64'hCAFE0000CAFE0003, 64'hCAFE0000CAFE0002,
                   64'hCAFE0000CAFE0001, 64'hCAFE0000CAFE0000};
        h_line  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                   64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};

        // Reset state.
        #2;
        check("rst resp_o", 256'(resp_o), 256'(0));
        check("rst read_o", 256'(read_o), 256'(0));
        check("rst write_o", 256'(write_o), 256'(0));
        check("rst line_o", line_o, 256'(0));
        check("rst burst_o", 256'(burst_o), 256'(0));
        check("rst address_o", 256'(address_o), 256'(0));
        step();
        rst = 1'b1;
        step();

        // Read with back-to-back beats.
        read_line("rd", 32'h0000_1234, 32'h0000_1220, rd_line);

        // Write with stalls: resp_i 1,0,0,1,1,0,1.
        exp_beat = '{wr_line[63:0], wr_line[127:64], wr_line[127:64], wr_line[127:64],
                     wr_line[191:128], wr_line[255:192], wr_line[255:192]};
        wr_resp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        line_i    = wr_line;
        write_i   = 1'b1;
        address_i = 32'hABCD_EF7F;
        step();
        for (int c = 0; c < 7; c++) begin
            check($sformatf("wr burst_o c%0d", c + 1), 256'(burst_o), 256'(exp_beat[c]));
            check($sformatf("wr write_o c%0d", c + 1), 256'(write_o), 256'(1));
            check($sformatf("wr resp_o c%0d", c + 1), 256'(resp_o), 256'(0));
            check($sformatf("wr addr c%0d", c + 1), 256'(address_o), 256'(32'hABCD_EF60));
            resp_i = wr_resp[c];
            step();
        end
        check("wr resp_o done", 256'(resp_o), 256'(1));
        check("wr write_o done", 256'(write_o), 256'(0));
        write_i = 1'b0;
        resp_i  = 1'b0;
        step();
        check("wr resp_o idle", 256'(resp_o), 256'(0));

        // Simultaneous read and write: read wins, line_i not latched.
        read_i    = 1'b1;
        write_i   = 1'b1;
        line_i    = x_line;
        address_i = 32'h0000_0040;
        step();
        check("rw read_o", 256'(read_o), 256'(1));
        check("rw write_o", 256'(write_o), 256'(0));
        check("rw line_o kept", line_o, wr_line);
        write_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_i = e_line[k*64 +: 64];
            resp_i  = 1'b1;
            step();
        end
        check("rw resp_o", 256'(resp_o), 256'(1));
        check("rw line_o", line_o, e_line);
        read_i = 1'b0;
        resp_i = 1'b0;
        step();

        // Spurious resp_i in IDLE, then a read.
        resp_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("spur resp_o c%0d", c), 256'(resp_o), 256'(0));
            check($sformatf("spur read_o c%0d", c), 256'(read_o), 256'(0));
        end
        check("spur line_o", line_o, e_line);
        read_i    = 1'b1;
        address_i = 32'h8000_001F;
        step();
        burst_i = s_line[63:0];
        step();
        check("spur beat0", 256'(line_o[63:0]), 256'(s_line[63:0]));
        check("spur upper", 256'(line_o[255:64]), 256'(e_line[255:64]));
        for (int k = 1; k < 4; k++) begin
            burst_i = s_line[k*64 +: 64];
            step();
        end
        check("spur resp_o", 256'(resp_o), 256'(1));
        check("spur line_o done", line_o, s_line);
        read_i = 1'b0;
        resp_i = 1'b0;
        step();

        // Reset asserted during beat 2 of a read.
        read_i    = 1'b1;
        address_i = 32'h0000_2000;
        step();
        burst_i = 64'h1;
        resp_i  = 1'b1;
        step();
        burst_i = 64'h2;
        rst     = 1'b0;
        #1;
        check("mid rst read_o", 256'(read_o), 256'(0));
        check("mid rst resp_o", 256'(resp_o), 256'(0));
        check("mid rst line_o", line_o, 256'(0));
        check("mid rst address_o", 256'(address_o), 256'(0));
        read_i = 1'b0;
        resp_i = 1'b0;
        step();
        check("mid rst held", 256'(read_o), 256'(0));
        rst = 1'b1;
        step();
        check("post rst resp_o", 256'(resp_o), 256'(0));
        read_line("post rst", 32'h0000_3008, 32'h0000_3000, r_line);

        // Request held through DONE: one pulse, retrigger from IDLE.
        read_i    = 1'b1;
        address_i = 32'h0000_4000;
        step();
        for (int k = 0; k < 4; k++) begin
            burst_i = h_line[k*64 +: 64];
            resp_i  = 1'b1;
            step();
        end
        resp_i = 1'b0;
        check("held resp_o c5", 256'(resp_o), 256'(1));
        check("held line_o", line_o, h_line);
        step();
        check("held resp_o c6", 256'(resp_o), 256'(0));
        check("held read_o c6", 256'(read_o), 256'(0));
        step();
        check("held read_o c7", 256'(read_o), 256'(1));
        check("held resp_o c7", 256'(resp_o), 256'(0));
        read_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            burst_i = 64'(k + 100);
            resp_i  = 1'b1;
            step();
        end
        resp_i = 1'b0;
        check("held2 resp_o", 256'(resp_o), 256'(1));
        step();
        check("held2 resp_o idle", 256'(resp_o), 256'(0));
        step();
        check("held2 no retrigger", 256'(read_o), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
